i2c_reg_bank: RTL and testbench

//  - Byte-wide register bank behind the I2C slave's register interface; services every reg_request with a fixed-latency reg_response.
//  - Exports RW control bytes and write strobes to fabric; imports RO status bytes as a coherent snapshot.
//  - Withholding reg_response on illegal writes makes the upstream slave NACK the master.

---
 rtl/i2c_reg_bank_pkg.sv | 17 +
 rtl/i2c_reg_bank_if.sv | 21 ++
 rtl/i2c_reg_bank_irq.sv | 39 +++
 rtl/i2c_reg_bank.sv | 158 +++++++++++++++
 tb/tb_i2c_reg_bank.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/i2c_reg_bank_pkg.sv
// rtl/i2c_reg_bank_pkg.sv - address map, FSM state type and helpers for the I2C register bank
package i2c_reg_bank_pkg;

    localparam int ADDR_ID          = 32'h00;
    localparam int ADDR_ERR_CNT     = 32'h01;
    localparam int ADDR_IRQ_STATUS  = 32'h02;
    localparam int ADDR_IRQ_MASK    = 32'h03;
    localparam int ADDR_CTRL_BASE   = 32'h10;
    localparam int ADDR_STATUS_BASE = 32'h20;

    typedef enum logic {IDLE, BUSY} bank_state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/i2c_reg_bank_if.sv
// rtl/i2c_reg_bank_if.sv - register request/response bus between the I2C slave and the register bank
interface i2c_reg_bank_if #(
    parameter int ADDR_WIDTH = 8
) ();
    logic [ADDR_WIDTH-1:0] reg_address;
    logic                  reg_is_write;
    logic                  reg_request;
    logic [7:0]            reg_write_data;
    logic                  reg_response;
    logic [7:0]            reg_read_data;

    modport master (
        output reg_address, reg_is_write, reg_request, reg_write_data,
        input  reg_response, reg_read_data
    );

    modport slave (
        input  reg_address, reg_is_write, reg_request, reg_write_data,
        output reg_response, reg_read_data
    );
endinterface

// File: rtl/i2c_reg_bank_irq.sv
// rtl/i2c_reg_bank_irq.sv - interrupt edge detect, W1C status, mask and registered irq output
module i2c_reg_bank_irq (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] irq_in,
    input  logic       w1c_valid,
    input  logic       mask_write,
    input  logic [7:0] write_data,
    output logic [7:0] irq_status,
    output logic [7:0] irq_mask,
    output logic       irq
);
    logic [7:0] irq_in_q;
    logic [7:0] irq_in_prev;
    logic [7:0] rise;
    logic [7:0] clear;

    assign rise  = irq_in_q & ~irq_in_prev;
    assign clear = w1c_valid ? write_data : 8'h00;

    always_ff @(posedge clock) begin
        if (reset) begin
            irq_in_q    <= 8'h00;
            irq_in_prev <= 8'h00;
            irq_status  <= 8'h00;
            irq_mask    <= 8'h00;
            irq         <= 1'b0;
        end else begin
            irq_in_q    <= irq_in;
            irq_in_prev <= irq_in_q;
            // A new edge in the same cycle as a clear keeps the bit set.
            irq_status  <= (irq_status & ~clear) | rise;
            if (mask_write) begin
                irq_mask <= write_data;
            end
            irq         <= |(irq_status & irq_mask);
        end
    end
endmodule

// File: rtl/i2c_reg_bank.sv
// rtl/i2c_reg_bank.sv - byte register bank with fixed-latency responses; IRQ block under I2C_REG_BANK_IRQ_EN
module i2c_reg_bank
    import i2c_reg_bank_pkg::*;
#(
    parameter int         ADDR_WIDTH = 8,
    parameter int         NUM_RW     = 8,
    parameter int         NUM_RO     = 4,
    parameter int         LATENCY    = 1,
    parameter logic [7:0] ID_VALUE   = 8'hA5
) (
    input  logic                 clock,
    input  logic                 reset,
    i2c_reg_bank_if.slave        bus,
    output logic [NUM_RW*8-1:0]  ctrl_regs,
    output logic [NUM_RW-1:0]    ctrl_wr_strobe,
    input  logic [NUM_RO*8-1:0]  status_in,
    input  logic [7:0]           irq_in,
    output logic                 irq
);
`ifdef I2C_REG_BANK_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif
    localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

    if (ADDR_WIDTH < 6)                 begin : g_bad_aw  $error("ADDR_WIDTH must be >= 6");    end
    if (NUM_RW < 1 || NUM_RW > 16)      begin : g_bad_rw  $error("NUM_RW must be 1..16");       end
    if (NUM_RO < 1 || NUM_RO > 16)      begin : g_bad_ro  $error("NUM_RO must be 1..16");       end
    if (LATENCY < 1 || LATENCY > 4)     begin : g_bad_lat $error("LATENCY must be 1..4");       end

    bank_state_t         state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                respond_q;
    logic [7:0]          rdata_q;
    logic [7:0]          err_cnt_q;
    logic [NUM_RO*8-1:0] snap_q;
    logic [NUM_RW*8-1:0] ctrl_q;
    logic [NUM_RW-1:0]   strobe_q;

    logic [31:0]         addr;
    logic                accept, overrun, is_ctrl, wr_legal, wr_ok;
    logic [NUM_RW-1:0]   ctrl_sel;
    logic [7:0]          rd_d;
    logic [7:0]          irq_status, irq_mask;

    // Address decode and read mux, evaluated on the request cycle.
    always_comb begin
        addr     = 32'(bus.reg_address);
        accept   = bus.reg_request && (state_q == IDLE);
        overrun  = bus.reg_request && (state_q == BUSY);
        is_ctrl  = 1'b0;
        ctrl_sel = '0;
        rd_d     = 8'h00;
        for (int i = 0; i < NUM_RW; i++) begin
            if (addr == 32'(ADDR_CTRL_BASE + i)) begin
                is_ctrl     = 1'b1;
                ctrl_sel[i] = 1'b1;
                rd_d        = ctrl_q[i*8 +: 8];
            end
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (addr == 32'(ADDR_STATUS_BASE + j)) begin
                rd_d = (j == 0) ? status_in[7:0] : snap_q[j*8 +: 8];
            end
        end
        if (addr == 32'(ADDR_ID))                    rd_d = ID_VALUE;
        if (addr == 32'(ADDR_ERR_CNT))               rd_d = err_cnt_q;
        if (IRQ_EN && addr == 32'(ADDR_IRQ_STATUS))  rd_d = irq_status;
        if (IRQ_EN && addr == 32'(ADDR_IRQ_MASK))    rd_d = irq_mask;
        wr_legal = is_ctrl || (addr == 32'(ADDR_ERR_CNT)) ||
                   (IRQ_EN && (addr == 32'(ADDR_IRQ_STATUS) || addr == 32'(ADDR_IRQ_MASK)));
        wr_ok    = accept && bus.reg_is_write && wr_legal;
    end

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        bus.reg_response  = 1'b0;
        bus.reg_read_data = 8'h00;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_q == 2'd0) begin
                    state_d           = IDLE;
                    bus.reg_response  = respond_q;
                    bus.reg_read_data = respond_q ? rdata_q : 8'h00;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            respond_q <= 1'b0;
            rdata_q   <= 8'h00;
            err_cnt_q <= 8'h00;
            snap_q    <= '0;
            ctrl_q    <= '0;
            strobe_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            strobe_q <= '0;
            if (accept) begin
                respond_q <= !bus.reg_is_write || wr_legal;
                rdata_q   <= bus.reg_is_write ? 8'h00 : rd_d;
                if (!bus.reg_is_write && addr == 32'(ADDR_STATUS_BASE)) begin
                    snap_q <= status_in;
                end
            end
            if (wr_ok && is_ctrl) begin
                for (int i = 0; i < NUM_RW; i++) begin
                    if (ctrl_sel[i]) ctrl_q[i*8 +: 8] <= bus.reg_write_data;
                end
                strobe_q <= ctrl_sel;
            end
            if (wr_ok && addr == 32'(ADDR_ERR_CNT)) begin
                err_cnt_q <= overrun ? 8'h01 : 8'h00;
            end else if (overrun) begin
                err_cnt_q <= sat_inc(err_cnt_q);
            end
        end
    end

    assign ctrl_regs      = ctrl_q;
    assign ctrl_wr_strobe = strobe_q;

`ifdef I2C_REG_BANK_IRQ_EN
    i2c_reg_bank_irq u_irq (
        .clock      (clock),
        .reset      (reset),
        .irq_in     (irq_in),
        .w1c_valid  (wr_ok && addr == 32'(ADDR_IRQ_STATUS)),
        .mask_write (wr_ok && addr == 32'(ADDR_IRQ_MASK)),
        .write_data (bus.reg_write_data),
        .irq_status (irq_status),
        .irq_mask   (irq_mask),
        .irq        (irq)
    );
`else
    logic unused_irq_in;
    assign unused_irq_in = ^irq_in;
    assign irq_status    = 8'h00;
    assign irq_mask      = 8'h00;
    assign irq           = 1'b0;
`endif
endmodule

// File: tb/tb_i2c_reg_bank.sv
// tb/tb_i2c_reg_bank.sv - directed self-checking bench for i2c_reg_bank at LATENCY 2 and 4
module tb_i2c_reg_bank;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] status_in = 32'h0;
    logic [7:0]  irq_in = 8'h00;
    logic [63:0] ctrl2, ctrl4;
    logic [7:0]  strobe2, strobe4;
    logic        irq2, irq4;

    int errors = 0;
    int checks = 0;
    int lat, nresp;
    logic [7:0] rd;
    logic       resp_hist   [1:8];
    logic [7:0] rd_hist     [1:8];
    logic [7:0] strobe_hist [1:8];
    logic [7:0] ctrl2_hist  [1:8];

    i2c_reg_bank_if #(.ADDR_WIDTH(8)) bus2 ();
    i2c_reg_bank_if #(.ADDR_WIDTH(8)) bus4 ();

    i2c_reg_bank #(.ADDR_WIDTH(8), .NUM_RW(8), .NUM_RO(4), .LATENCY(2), .ID_VALUE(8'hA5)) u_dut2 (
        .clock(clock), .reset(reset), .bus(bus2), .ctrl_regs(ctrl2), .ctrl_wr_strobe(strobe2),
        .status_in(status_in), .irq_in(irq_in), .irq(irq2)
    );
    i2c_reg_bank #(.ADDR_WIDTH(8), .NUM_RW(8), .NUM_RO(4), .LATENCY(4), .ID_VALUE(8'hA5)) u_dut4 (
        .clock(clock), .reset(reset), .bus(bus4), .ctrl_regs(ctrl4), .ctrl_wr_strobe(strobe4),
        .status_in(status_in), .irq_in(irq_in), .irq(irq4)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input logic req, input logic [7:0] a, input logic w, input logic [7:0] d);
        if (s) begin
            bus4.reg_request = req; bus4.reg_address = a; bus4.reg_is_write = w; bus4.reg_write_data = d;
        end else begin
            bus2.reg_request = req; bus2.reg_address = a; bus2.reg_is_write = w; bus2.reg_write_data = d;
        end
    endtask

    // Issues one request (cycle 0) and records 8 following cycles; optional overrun request / reset pulse.
    task automatic txn(input bit s, input logic [7:0] a, input logic w, input logic [7:0] d,
                       input int extra_at, input int rst_at);
        logic r;
        drive(s, 1'b1, a, w, d);
        @(posedge clock); #1;
        drive(s, 1'b0, 8'h00, 1'b0, 8'h00);
        lat = -1; nresp = 0; rd = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            if (i == extra_at) drive(s, 1'b1, 8'h11, 1'b1, 8'h77);
            if (i == rst_at) reset = 1'b1;
            @(negedge clock);
            r              = s ? bus4.reg_response : bus2.reg_response;
            resp_hist[i]   = r;
            rd_hist[i]     = s ? bus4.reg_read_data : bus2.reg_read_data;
            strobe_hist[i] = s ? strobe4 : strobe2;
            ctrl2_hist[i]  = ctrl2[23:16];
            if (r === 1'b1) begin
                nresp++;
                if (lat < 0) begin
                    lat = i;
                    rd  = rd_hist[i];
                end
            end
            @(posedge clock); #1;
            if (i == extra_at) drive(s, 1'b0, 8'h00, 1'b0, 8'h00);
            if (i == rst_at) reset = 1'b0;
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_response", 32'(bus2.reg_response), 32'h0);
        check("reset_read_data", 32'(bus2.reg_read_data), 32'h0);
        check("reset_ctrl", ctrl2[31:0], 32'h0);
        check("reset_strobe", 32'(strobe2), 32'h0);
        check("reset_irq", 32'(irq2), 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        txn(1'b0, 8'h12, 1'b1, 8'h3C, 0, 0);
        check("ctrl_visible_req1", 32'(ctrl2_hist[1]), 32'h3C);
        check("ctrl_strobe_req1", 32'(strobe_hist[1]), 32'h04);
        check("ctrl_strobe_req2", 32'(strobe_hist[2]), 32'h00);
        check("ctrl_no_resp_req1", 32'(resp_hist[1]), 32'h0);
        check("ctrl_resp_latency", 32'(lat), 32'd2);
        check("ctrl_resp_count", 32'(nresp), 32'd1);

        txn(1'b0, 8'h00, 1'b0, 8'h00, 0, 0);
        check("id_latency", 32'(lat), 32'd2);
        check("id_value", 32'(rd), 32'hA5);
        check("id_data_cleared", 32'(rd_hist[3]), 32'h00);
        txn(1'b0, 8'h3F, 1'b0, 8'h00, 0, 0);
        check("unmapped_latency", 32'(lat), 32'd2);
        check("unmapped_value", 32'(rd), 32'h00);
        txn(1'b0, 8'h12, 1'b0, 8'h00, 0, 0);
        check("ctrl_readback", 32'(rd), 32'h3C);

        txn(1'b0, 8'h00, 1'b1, 8'hFF, 0, 0);
        check("illegal_id_write_nack", 32'(nresp), 32'd0);
        txn(1'b0, 8'h21, 1'b1, 8'h01, 0, 0);
        check("illegal_status_write_nack", 32'(nresp), 32'd0);
        txn(1'b0, 8'h00, 1'b0, 8'h00, 0, 0);
        check("id_after_illegal", 32'(rd), 32'hA5);

        status_in = 32'h44332211;
        txn(1'b0, 8'h20, 1'b0, 8'h00, 0, 0);
        check("snap_byte0", 32'(rd), 32'h11);
        status_in = 32'hDDCCBBAA;
        txn(1'b0, 8'h21, 1'b0, 8'h00, 0, 0);
        check("snap_byte1", 32'(rd), 32'h22);
        txn(1'b0, 8'h23, 1'b0, 8'h00, 0, 0);
        check("snap_byte3", 32'(rd), 32'h44);
        txn(1'b0, 8'h20, 1'b0, 8'h00, 0, 0);
        check("snap_recapture", 32'(rd), 32'hAA);

        txn(1'b1, 8'h10, 1'b0, 8'h00, 1, 0);
        check("overrun_latency", 32'(lat), 32'd4);
        check("overrun_one_resp", 32'(nresp), 32'd1);
        txn(1'b1, 8'h01, 1'b0, 8'h00, 0, 0);
        check("overrun_err_cnt", 32'(rd), 32'h01);
        txn(1'b1, 8'h11, 1'b0, 8'h00, 0, 0);
        check("overrun_no_side_effect", 32'(rd), 32'h00);
        txn(1'b0, 8'h01, 1'b0, 8'h00, 0, 0);
        check("other_err_cnt_zero", 32'(rd), 32'h00);
        txn(1'b1, 8'h01, 1'b1, 8'h55, 0, 0);
        check("err_clear_resp", 32'(lat), 32'd4);
        txn(1'b1, 8'h01, 1'b0, 8'h00, 0, 0);
        check("err_cnt_cleared", 32'(rd), 32'h00);

        txn(1'b1, 8'h00, 1'b0, 8'h00, 0, 2);
        check("reset_mid_no_resp", 32'(nresp), 32'd0);
        txn(1'b0, 8'h12, 1'b0, 8'h00, 0, 0);
        check("ctrl_after_reset", 32'(rd), 32'h00);

`ifdef I2C_REG_BANK_IRQ_EN
        txn(1'b0, 8'h03, 1'b1, 8'h01, 0, 0);
        check("irq_mask_write", 32'(nresp), 32'd1);
        irq_in = 8'h01;
        repeat (4) @(posedge clock);
        #1; irq_in = 8'h00;
        @(negedge clock);
        check("irq_asserted", 32'(irq2), 32'h1);
        @(posedge clock); #1;
        txn(1'b0, 8'h02, 1'b1, 8'h01, 0, 0);
        check("irq_w1c_resp", 32'(nresp), 32'd1);
        @(negedge clock);
        check("irq_cleared", 32'(irq2), 32'h0);
        @(posedge clock); #1;
        irq_in = 8'h01;
        @(posedge clock); #1;
        txn(1'b0, 8'h02, 1'b1, 8'h01, 0, 0);
        irq_in = 8'h00;
        txn(1'b0, 8'h02, 1'b0, 8'h00, 0, 0);
        check("irq_set_wins", 32'(rd), 32'h01);
`else
        txn(1'b0, 8'h02, 1'b0, 8'h00, 0, 0);
        check("irq_status_unmapped_resp", 32'(nresp), 32'd1);
        check("irq_status_unmapped_val", 32'(rd), 32'h00);
        txn(1'b0, 8'h03, 1'b1, 8'h01, 0, 0);
        check("irq_mask_write_nack", 32'(nresp), 32'd0);
        irq_in = 8'hFF;
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("irq_tied_low", 32'(irq2), 32'h0);
        irq_in = 8'h00;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
